blitter_mem_arbiter: RTL and testbench
======================================

Name: blitter_mem_arbiter

Overview:
- Shares the single SDRAM burst-read port among NUM_REQ burst-read requesters: blitter source cache, blitter destination cache, pattern/texture cache.
- Each requester uses the same interface as the blitter cache memory port: address, level request, data, valid, complete.
- Arbitration is round-robin, one burst at a time. Read data is broadcast and each valid/complete pulse is steered to the granted requester.
- Sits between the blitter caches and the SDRAM controller read port.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- BURST_LEN, 8, 32-bit beats per burst; used only for beat checking.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_address  in  26*NUM_REQ  requester i address at bits [26*i+25:26*i]; 32-byte aligned.
- req_request  in  NUM_REQ  level request; requester holds it until its first valid.
- req_data  out  32  mem_data passed through combinationally to all requesters.
- req_valid  out  NUM_REQ  per-requester beat strobe.
- req_complete  out  NUM_REQ  per-requester end-of-burst pulse.
- mem_address  out  26  burst address to SDRAM controller.
- mem_request  out  1  burst request to SDRAM controller.
- mem_data  in  32  SDRAM read data.
- mem_valid  in  1  SDRAM beat strobe.
- mem_complete  in  1  SDRAM burst done.
- grant  out  2  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.
- beat_error  out  1  sticky; set when the beat count at mem_complete is not BURST_LEN.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; mem_request = 0; mem_address = 0; grant = NUM_REQ-1, so requester 0 wins first; beat count = 0; beat_error = 0.
  - req_valid and req_complete are 0 whenever state is IDLE.
- States: IDLE, ISSUE, BURST.
- IDLE:
  - If any req_request bit is set, pick the first set bit scanning grant+1, grant+2, … modulo NUM_REQ.
  - Register grant and mem_address <= req_address[winner], with bits [4:0] forced to 0. Set mem_request <= 1 and beat count <= 0. Go to ISSUE.
  - Grant decision to mem_request high: 1 cycle.
  - mem_valid or mem_complete seen in IDLE is ignored; it does not affect beat_error.
- ISSUE:
  - mem_request and mem_address are held stable until the first mem_valid.
  - On that first mem_valid: mem_request <= 0, forward the beat, beat count <= 1, go to BURST.
- BURST:
  - Each mem_valid increments the beat count; the count saturates at 15.
- Valid steering, all states except IDLE:
  - req_valid[grant] = mem_valid, combinational and same cycle; all other bits are 0.
  - req_data = mem_data, always.
- Complete:
  - When mem_complete is high in ISSUE or BURST: req_complete[grant] = 1 for that cycle, state <= IDLE.
  - If the beat count including this cycle's valid is not BURST_LEN, set beat_error.
  - mem_valid and mem_complete in the same cycle: the beat is forwarded and counted, then the burst completes.
  - mem_complete in ISSUE with no valid: the burst ends with a count of 0 (an error); mem_request <= 0.
- Request handling:
  - req_request of the granted requester is ignored from grant until IDLE.
  - Requests arriving mid-burst wait; no request is ever lost while held.
- Back-to-back bursts: from mem_complete to the next mem_request takes 2 cycles (IDLE decision, then ISSUE).
- A requester whose request is still high one cycle after complete gets re-granted only if no other requester is pending.
- Reset mid-burst: the in-flight burst is abandoned and outputs are cleared immediately. The downstream controller must itself be reset by the same reset_n.

Optional Feature:
- Macro: BLIT_ARB_PRIORITY_EN.
- When defined: requester 0 (blitter source cache) has fixed highest priority. The other requesters round-robin among themselves only when req_request[0] is low.
- When undefined: pure round-robin across all NUM_REQ requesters as above.

Test Plan:
- Single requester:
  - Stimulus: after reset, req 1 requests address 26'h0123456.
  - Required: grant=1; mem_address=26'h0123440; mem_request high 1 cycle after the request, dropped after the first valid.
  - Required: 8 req_valid[1] pulses with data matching mem_data; req_complete[1] pulse; beat_error=0.
- Contention: reqs 0, 1, 2 all held continuously -> grants in order 0,1,2,0; each mem_request rises exactly 2 cycles after the previous mem_complete.
- Same-cycle end: mem_valid and mem_complete both high on beat 8 -> 8 valids forwarded, complete pulsed, beat_error stays 0.
- Short burst: mem_complete after 5 beats -> beat_error=1 and stays set across later good bursts until reset.
- Mid-burst reset: reset_n low during beat 3 -> mem_request=0, busy=0, req_valid=0 at once; after release, a pending req 2 is granted fresh with address reissued.
- With BLIT_ARB_PRIORITY_EN: reqs 0 and 2 continuously high -> req 0 granted every burst; req 2 granted once req 0 drops.

Source files
------------

// File: rtl/blitter_mem_arbiter_if.sv
// blitter_mem_arbiter_if: requester-side and SDRAM-side burst-read signals of the blitter memory arbiter.
// master = arbiter view, slave = environment view (caches plus SDRAM controller).
interface blitter_mem_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [26*NUM_REQ-1:0] req_address;
    logic [NUM_REQ-1:0]    req_request;
    logic [31:0]           req_data;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_complete;
    logic [25:0]           mem_address;
    logic                  mem_request;
    logic [31:0]           mem_data;
    logic                  mem_valid;
    logic                  mem_complete;

    modport master (
        input  req_address, req_request, mem_data, mem_valid, mem_complete,
        output req_data, req_valid, req_complete, mem_address, mem_request
    );

    modport slave (
        output req_address, req_request, mem_data, mem_valid, mem_complete,
        input  req_data, req_valid, req_complete, mem_address, mem_request
    );
endinterface

// File: rtl/blitter_mem_arbiter.sv
// blitter_mem_arbiter: round-robin sharing of one SDRAM burst-read port among NUM_REQ blitter caches.
// Define BLIT_ARB_PRIORITY_EN to give requester 0 fixed priority over the round-robin of the others.
module blitter_mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int BURST_LEN = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    blitter_mem_arbiter_if.master bus,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  beat_error
);
    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [25:0] mem_address_q, mem_address_d;
    logic        mem_request_q, mem_request_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        beat_error_q, beat_error_d;
    logic [3:0]  req_pad;
    logic [1:0]  idx;
    logic [1:0]  winner;
    logic [25:0] sel_addr;
    logic [3:0]  cnt_inc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= 2'(NUM_REQ - 1);
            mem_address_q <= '0;
            mem_request_q <= 1'b0;
            beat_cnt_q    <= '0;
            beat_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_address_q <= mem_address_d;
            mem_request_q <= mem_request_d;
            beat_cnt_q    <= beat_cnt_d;
            beat_error_q  <= beat_error_d;
        end
    end

    // Scan from farthest to nearest so the nearest pending requester after grant_q wins.
    always_comb begin
        req_pad = 4'(bus.req_request);
        idx     = '0;
        winner  = grant_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 2'((int'(grant_q) + k) % NUM_REQ);
            if (req_pad[idx]) winner = idx;
        end
`ifdef BLIT_ARB_PRIORITY_EN
        if (req_pad[0]) winner = 2'd0;
`endif
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (winner == 2'(i)) sel_addr = bus.req_address[26*i +: 26];
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_address_d = mem_address_q;
        mem_request_d = mem_request_q;
        beat_cnt_d    = beat_cnt_q;
        beat_error_d  = beat_error_q;
        cnt_inc       = (bus.mem_valid && beat_cnt_q != 4'd15) ? beat_cnt_q + 4'd1 : beat_cnt_q;
        if (state_q == IDLE) begin
            if (|bus.req_request) begin
                grant_d       = winner;
                mem_address_d = {sel_addr[25:5], 5'd0};
                mem_request_d = 1'b1;
                beat_cnt_d    = '0;
                state_d       = ISSUE;
            end
        end else begin
            beat_cnt_d = cnt_inc;
            if (bus.mem_valid) begin
                mem_request_d = 1'b0;
                if (state_q == ISSUE) state_d = BURST;
            end
            // The beat arriving with mem_complete is counted before the length check.
            if (bus.mem_complete) begin
                state_d       = IDLE;
                mem_request_d = 1'b0;
                if (int'(cnt_inc) != BURST_LEN) beat_error_d = 1'b1;
            end
        end
    end

    assign busy             = state_q != IDLE;
    assign grant            = grant_q;
    assign beat_error       = beat_error_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_request  = mem_request_q;
    assign bus.req_data     = bus.mem_data;
    assign bus.req_valid    = busy ? (NUM_REQ'(bus.mem_valid) << grant_q) : '0;
    assign bus.req_complete = busy ? (NUM_REQ'(bus.mem_complete) << grant_q) : '0;
endmodule

// File: tb/tb_blitter_mem_arbiter.sv
// tb_blitter_mem_arbiter: table-driven and randomized checks of blitter_mem_arbiter against a reference model.
// Honours BLIT_ARB_PRIORITY_EN so the same bench covers both builds.
module tb_blitter_mem_arbiter;
    localparam int N = 3;
`ifdef BLIT_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic        beat_error;
    int          tests = 0;
    int          fails = 0;
    int          m_grant;
    bit          m_err;
    logic [25:0] addrs [N];

    typedef struct {
        logic [N-1:0] mask;
        int           beats;
        bit           same;
        int           exp_grant;
        bit           exp_err;
    } vec_t;
    vec_t vecs [9];

    blitter_mem_arbiter_if #(.NUM_REQ(N)) bus ();

    blitter_mem_arbiter #(.NUM_REQ(N), .BURST_LEN(8)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus),
        .grant(grant),
        .busy(busy),
        .beat_error(beat_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_addrs();
        bus.req_address = {addrs[2], addrs[1], addrs[0]};
    endtask

    // Nearest pending requester going forward from the last grant, with optional fixed priority for 0.
    function automatic int model_pick(input logic [N-1:0] mask, input int last);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        if (PRIO && mask[0]) return 0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - last - 1 + 2*N) % N;
            if (mask[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic start_burst(input logic [N-1:0] mask, input int exp_g, input string tag);
        int n;
        n = 0;
        bus.req_request = mask;
        while (n < 10 && bus.mem_request !== 1'b1) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 1);
        chk({tag, "_grant"}, grant, exp_g);
        chk({tag, "_addr"}, bus.mem_address, {addrs[exp_g][25:5], 5'd0});
        chk({tag, "_busy"}, busy, 1);
        m_grant = exp_g;
    endtask

    task automatic do_burst(input int g, input int nb, input bit same, input bit gaps);
        int b;
        logic [31:0] d;
        logic [N-1:0] onehot;
        b = 0;
        onehot = N'(1) << g;
        while (b < nb) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.mem_valid = 1'b0;
                bus.mem_complete = 1'b0;
                #1;
                chk("gap_valid", bus.req_valid, 0);
                chk("gap_busy", busy, 1);
                if (b == 0) chk("hold_req", bus.mem_request, 1);
                @(posedge clock); #1;
            end else begin
                d = $urandom;
                bus.mem_data = d;
                bus.mem_valid = 1'b1;
                bus.mem_complete = same && (b == nb - 1);
                #1;
                chk("beat_valid", bus.req_valid, onehot);
                chk("beat_data", bus.req_data, d);
                chk("beat_cmpl", bus.req_complete, bus.mem_complete ? onehot : '0);
                @(posedge clock); #1;
                if (b == 0) chk("req_drop", bus.mem_request, 0);
                b++;
            end
        end
        if (!same) begin
            bus.mem_valid = 1'b0;
            bus.mem_complete = 1'b1;
            #1;
            chk("cmpl_pulse", bus.req_complete, onehot);
            chk("cmpl_valid", bus.req_valid, 0);
            @(posedge clock); #1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_complete = 1'b0;
        #1;
        chk("end_busy", busy, 0);
        chk("end_req", bus.mem_request, 0);
    endtask

    initial begin
        bus.req_request = '0;
        bus.mem_data = '0;
        bus.mem_valid = 1'b0;
        bus.mem_complete = 1'b0;
        addrs[0] = 26'h0000A5F;
        addrs[1] = 26'h0123456;
        addrs[2] = 26'h3FFFFFF;
        set_addrs();
        m_grant = N - 1;
        m_err = 1'b0;
        vecs[0] = '{3'b010, 8, 1'b0, 1, 1'b0};
        vecs[1] = '{3'b111, 8, 1'b0, PRIO ? 0 : 2, 1'b0};
        vecs[2] = '{3'b111, 8, 1'b1, 0, 1'b0};
        vecs[3] = '{3'b111, 8, 1'b1, PRIO ? 0 : 1, 1'b0};
        vecs[4] = '{3'b111, 8, 1'b0, PRIO ? 0 : 2, 1'b0};
        vecs[5] = '{3'b111, 8, 1'b0, 0, 1'b0};
        vecs[6] = '{3'b001, 5, 1'b0, 0, 1'b1};
        vecs[7] = '{3'b110, 8, 1'b0, 1, 1'b1};
        vecs[8] = '{3'b100, 0, 1'b0, 2, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 2);
        chk("rst_req", bus.mem_request, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_err", beat_error, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        bus.mem_valid = 1'b1;
        bus.mem_complete = 1'b1;
        #1;
        chk("idle_valid", bus.req_valid, 0);
        chk("idle_cmpl", bus.req_complete, 0);
        @(posedge clock); #1;
        bus.mem_valid = 1'b0;
        bus.mem_complete = 1'b0;
        chk("idle_err", beat_error, 0);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            start_burst(vecs[i].mask, vecs[i].exp_grant, $sformatf("v%0d", i));
            do_burst(vecs[i].exp_grant, vecs[i].beats, vecs[i].same, 1'b0);
            chk($sformatf("v%0d_err", i), beat_error, vecs[i].exp_err);
        end

        start_burst(3'b101, 0, "pre_rst");
        for (int b = 0; b < 2; b++) begin
            bus.mem_valid = 1'b1;
            bus.mem_data = $urandom;
            @(posedge clock); #1;
        end
        bus.mem_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mrst_req", bus.mem_request, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", bus.req_valid, 0);
        chk("mrst_err", beat_error, 0);
        chk("mrst_grant", grant, 2);
        bus.mem_valid = 1'b0;
        bus.req_request = 3'b100;
        @(posedge clock); #1;
        reset_n = 1'b1;
        m_err = 1'b0;
        start_burst(3'b100, 2, "post_rst");
        do_burst(2, 8, 1'b0, 1'b0);
        chk("post_rst_err", beat_error, 0);

`ifdef BLIT_ARB_PRIORITY_EN
        for (int i = 0; i < 2; i++) begin
            start_burst(3'b101, 0, "prio0");
            do_burst(0, 8, 1'b0, 1'b0);
        end
        start_burst(3'b100, 2, "prio2");
        do_burst(2, 8, 1'b0, 1'b0);
`endif

        bus.req_request = '0;
        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] mask;
            int nb;
            bit same;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
                chk("rnd_idle", busy, 0);
            end
            for (int i = 0; i < N; i++) addrs[i] = 26'($urandom);
            set_addrs();
            mask = N'($urandom_range(1, 7));
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : 8;
            same = ($urandom_range(0, 1) == 1) && (nb > 0);
            start_burst(mask, model_pick(mask, m_grant), "rnd");
            do_burst(m_grant, nb, same, 1'b1);
            if (nb != 8) m_err = 1'b1;
            chk("rnd_err", beat_error, m_err);
            bus.req_request = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
